// File: rtl/tick_timer_bank.sv
// tick_timer_bank: independent programmable tick channels (periodic or one-shot) with pause, restart and per-channel period writes.
module tick_timer_bank #(
    parameter int WIDTH          = 31,
    parameter int CHANNELS       = 4,
    parameter int CH_BITS        = 2,
    parameter int DEFAULT_PERIOD = 1_000_000
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_en,
    input  logic [CHANNELS-1:0] i_oneshot,
    input  logic [CHANNELS-1:0] i_start,
    input  logic                i_wr_en,
    input  logic [CH_BITS-1:0]  i_wr_ch,
    input  logic [WIDTH-1:0]    i_wr_period,
    output logic [CHANNELS-1:0] o_pulse,
    output logic [CHANNELS-1:0] o_busy
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_period;
        logic             r_armed;
        logic             r_pulse;
        logic             w_wr;
        logic             w_run;
        // out-of-range channel numbers never match any instance, so such writes fall through
        assign w_wr  = i_wr_en && (i_wr_ch == CH_BITS'(c));
        assign w_run = r_armed && i_en[c];
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_cnt    <= '0;
                r_period <= WIDTH'(DEFAULT_PERIOD);
                r_armed  <= 1'b1;
                r_pulse  <= 1'b0;
            end else if (w_wr) begin
                r_period <= i_wr_period;
                r_cnt    <= '0;
                r_armed  <= 1'b1;
                r_pulse  <= 1'b0;
            end else if (i_start[c]) begin
                r_cnt    <= '0;
                r_armed  <= 1'b1;
                r_pulse  <= 1'b0;
            end else if (w_run && r_cnt == r_period) begin
                r_cnt    <= '0;
                r_pulse  <= 1'b1;
                if (i_oneshot[c])
                    r_armed <= 1'b0;
            end else if (w_run) begin
                r_cnt    <= r_cnt + 1'b1;
                r_pulse  <= 1'b0;
            end else begin
                r_pulse  <= 1'b0;
            end
        end
        assign o_pulse[c] = r_pulse;
        assign o_busy[c]  = r_armed;
    end
endmodule

// File: tb/tb_tick_timer_bank.sv
// tb_tick_timer_bank: randomized and directed checks of tick_timer_bank against a countdown-to-tick reference model.
module tb_tick_timer_bank;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] en, oneshot, start, pulse, busy;
    logic       wr_en;
    logic [0:0] wr_ch;
    logic [7:0] wr_period;

    logic       b_rst_n;
    logic [2:0] b_en, b_os, b_start, b_pulse, b_busy;
    logic       b_wr_en;
    logic [1:0] b_wr_ch;
    logic [7:0] b_wr_period;

    tick_timer_bank #(.WIDTH(8), .CHANNELS(2), .CH_BITS(1), .DEFAULT_PERIOD(3)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_en(en), .i_oneshot(oneshot), .i_start(start),
        .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_period(wr_period), .o_pulse(pulse), .o_busy(busy));

    tick_timer_bank #(.WIDTH(8), .CHANNELS(3), .CH_BITS(2), .DEFAULT_PERIOD(3)) dut_b (
        .i_clock(clk), .i_reset_n(b_rst_n), .i_en(b_en), .i_oneshot(b_os), .i_start(b_start),
        .i_wr_en(b_wr_en), .i_wr_ch(b_wr_ch), .i_wr_period(b_wr_period), .o_pulse(b_pulse), .o_busy(b_busy));

    int         n_cmp = 0;
    int         n_bad = 0;
    // model: remaining enabled edges until the next tick, reloaded with period+1
    int         m_per[2];
    int         m_rem[2];
    logic [1:0] m_arm, m_pulse;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_per[i] = 3;
            m_rem[i] = 4;
            m_arm[i] = 1'b1;
            m_pulse[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pulse[i] = 1'b0;
                if (wr_en && int'(wr_ch) == i) begin
                    m_per[i] = int'(wr_period);
                    m_rem[i] = m_per[i] + 1;
                    m_arm[i] = 1'b1;
                end else if (start[i]) begin
                    m_rem[i] = m_per[i] + 1;
                    m_arm[i] = 1'b1;
                end else if (m_arm[i] && en[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_pulse[i] = 1'b1;
                        m_rem[i] = m_per[i] + 1;
                        if (oneshot[i]) m_arm[i] = 1'b0;
                    end
                end
            end
        end
        #2;
    endtask

    task automatic write_main(input logic ch, input logic [7:0] p);
        wr_en = 1'b1; wr_ch = ch; wr_period = p;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 2'b11; oneshot = 2'b00; start = 2'b00;
        wr_en = 1'b0; wr_ch = '0; wr_period = '0;
        b_rst_n = 1'b0; b_en = 3'b111; b_os = '0; b_start = '0;
        b_wr_en = 1'b0; b_wr_ch = '0; b_wr_period = '0;
        #23;
        n_cmp++;
        if (pulse !== 2'b00 || busy !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_state pulse=%b busy=%b expected pulse=00 busy=11", pulse, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_periodic();
        for (int k = 1; k <= 13; k++) begin
            step();
            n_cmp++;
            if (pulse !== ((k % 4 == 0) ? 2'b11 : 2'b00) || busy !== 2'b11 || pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL periodic edge=%0d pulse=%b busy=%b expected pulse=%b busy=11",
                         k, pulse, busy, (k % 4 == 0) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_write_period();
        write_main(1'b1, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (pulse[1] !== 1'b1 || pulse !== m_pulse || busy !== m_arm) begin
                n_bad++;
                $display("FAIL period0 k=%0d pulse=%b busy=%b expected pulse=%b busy=%b", k, pulse, busy, m_pulse, m_arm);
            end
        end
        write_main(1'b1, 8'd5);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (pulse[1] !== (k == 6 || k == 12) || pulse !== m_pulse || busy !== m_arm) begin
                n_bad++;
                $display("FAIL period5 k=%0d pulse=%b busy=%b expected pulse=%b busy=%b", k, pulse, busy, m_pulse, m_arm);
            end
        end
        write_main(1'b1, 8'd255);
        for (int k = 1; k <= 258; k++) begin
            step();
            n_cmp++;
            if (pulse[1] !== (k == 256) || pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL period255 k=%0d pulse=%b expected pulse1=%b model=%b", k, pulse, k == 256, m_pulse);
            end
        end
        write_main(1'b1, 8'd3);
    endtask

    task automatic test_oneshot();
        oneshot = 2'b01; start = 2'b01;
        step();
        start = 2'b00;
        for (int k = 1; k <= 24; k++) begin
            step();
            n_cmp++;
            if (pulse[0] !== (k == 4) || busy[0] !== (k < 4) || pulse !== m_pulse || busy !== m_arm) begin
                n_bad++;
                $display("FAIL oneshot k=%0d pulse=%b busy=%b expected pulse0=%b busy0=%b", k, pulse, busy, k == 4, k < 4);
            end
        end
        start = 2'b01;
        step();
        start = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (pulse[0] !== (k == 4) || busy[0] !== (k < 4)) begin
                n_bad++;
                $display("FAIL oneshot_rearm k=%0d pulse=%b busy=%b expected pulse0=%b busy0=%b", k, pulse, busy, k == 4, k < 4);
            end
        end
        oneshot = 2'b00; start = 2'b01;
        step();
        start = 2'b00;
    endtask

    task automatic test_pause();
        start = 2'b01;
        step();
        start = 2'b00;
        step();
        en = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (pulse[0] !== 1'b0 || busy !== m_arm || pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL pause k=%0d pulse=%b busy=%b expected pulse=%b busy=%b", k, pulse, busy, m_pulse, m_arm);
            end
        end
        en = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (pulse[0] !== (k == 3) || pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL resume k=%0d pulse=%b expected pulse0=%b model=%b", k, pulse, k == 3, m_pulse);
            end
        end
    endtask

    task automatic test_terminal_collision();
        int tries = 0;
        while (m_rem[0] != 1 && tries < 10) begin step(); tries++; end
        n_cmp++;
        if (m_rem[0] != 1) begin
            n_bad++;
            $display("FAIL terminal_wait ch0 never reached terminal count within %0d cycles", tries);
        end
        write_main(1'b0, 8'd2);
        n_cmp++;
        if (pulse[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL write_on_terminal pulse0=%b expected 0", pulse[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (pulse[0] !== (k == 3)) begin
                n_bad++;
                $display("FAIL after_terminal_write k=%0d pulse0=%b expected %b", k, pulse[0], k == 3);
            end
        end
        tries = 0;
        while (m_rem[1] != 1 && tries < 10) begin step(); tries++; end
        start = 2'b10;
        step();
        start = 2'b00;
        n_cmp++;
        if (pulse[1] !== 1'b0 || m_pulse[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL start_on_terminal pulse1=%b expected 0", pulse[1]);
        end
        write_main(1'b0, 8'd3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en      = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
            start   = {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0};
            if ($urandom_range(0, 29) == 0) oneshot = 2'($urandom);
            wr_en     = $urandom_range(0, 14) == 0;
            wr_ch     = 1'($urandom);
            wr_period = 8'($urandom_range(0, 6));
            step();
            n_cmp++;
            if (pulse !== m_pulse || busy !== m_arm) begin
                n_bad++;
                $display("FAIL random k=%0d pulse=%b busy=%b expected pulse=%b busy=%b", k, pulse, busy, m_pulse, m_arm);
            end
        end
        en = 2'b11; start = 2'b00; oneshot = 2'b00; wr_en = 1'b0;
        write_main(1'b0, 8'd3);
        write_main(1'b1, 8'd3);
    endtask

    task automatic test_out_of_range();
        b_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            b_wr_en = (k == 3); b_wr_ch = 2'd3; b_wr_period = 8'd0;
            step();
            n_cmp++;
            if (b_pulse !== ((k % 4 == 0) ? 3'b111 : 3'b000) || b_busy !== 3'b111) begin
                n_bad++;
                $display("FAIL out_of_range_write k=%0d pulse=%b busy=%b expected pulse=%b busy=111",
                         k, b_pulse, b_busy, (k % 4 == 0) ? 3'b111 : 3'b000);
            end
        end
        b_wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int tries = 0;
        write_main(1'b1, 8'd5);
        while (pulse[1] !== 1'b1 && tries < 12) begin step(); tries++; end
        n_cmp++;
        if (pulse[1] !== 1'b1 || m_pulse[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL async_setup pulse1=%b model=%b expected 1", pulse[1], m_pulse[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pulse !== 2'b00 || busy !== 2'b11) begin
            n_bad++;
            $display("FAIL async_reset pulse=%b busy=%b expected pulse=00 busy=11", pulse, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (pulse !== ((k % 4 == 0) ? 2'b11 : 2'b00) || busy !== 2'b11 || pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL post_reset k=%0d pulse=%b busy=%b expected pulse=%b busy=11",
                         k, pulse, busy, (k % 4 == 0) ? 2'b11 : 2'b00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_write_period();
        test_oneshot();
        test_pause();
        test_terminal_collision();
        test_random();
        test_out_of_range();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
